// File: rtl/mips_alu_seq_if.sv
// Handshake/operand bundle between the execute stage and mips_alu_seq.
// master: pipeline side (issues ops, consumes results); slave: the ALU.
interface mips_alu_seq_if #(
  parameter int SIZE = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      ALUOp;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] outCalc;
  logic [SIZE-1:0] hi;
  logic            zero;
  logic            overflow;
  logic            div_zero;

  modport master (
    output in_valid, ALUOp, a, b, out_ready,
    input  in_ready, out_valid, outCalc, hi, zero, overflow, div_zero
  );

  modport slave (
    input  in_valid, ALUOp, a, b, out_ready,
    output in_ready, out_valid, outCalc, hi, zero, overflow, div_zero
  );
endinterface

// File: rtl/mips_alu_seq.sv
// Multi-cycle MIPS execute-stage ALU.
// Single-cycle logic/arith ops complete on the accepting edge; MULT/MULTU run a
// shift-add loop on operand magnitudes, one bit per cycle, into HI/LO.
// Optional feature macro: MIPS_ALU_DIV_EN enables DIV/DIVU (restoring divider).
// Without it DIV/DIVU behave as unknown opcodes and no divider is built.
module mips_alu_seq #(
  parameter int SIZE  = 32,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           rst_n,
  mips_alu_seq_if.slave bus
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
`ifdef MIPS_ALU_DIV_EN
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SIZE-1:0]   lo_q, lo_d;
  logic [SIZE-1:0]   hi_q, hi_d;
  logic              ovf_q, ovf_d;
  logic              dz_q, dz_d;
  // Iteration datapath: work_q holds {partial product, multiplier} for
  // multiplication or {partial remainder, dividend/quotient} for division.
  logic [2*SIZE-1:0] work_q, work_d;
  logic [SIZE-1:0]   mcand_q, mcand_d;
  logic              neg_lo_q, neg_lo_d;
`ifdef MIPS_ALU_DIV_EN
  logic              neg_hi_q, neg_hi_d;
  logic              is_div_q, is_div_d;
`endif

  // ---------------- single-cycle datapath (from live inputs) ----------------
  logic [SIZE-1:0] sum_w, diff_w;
  logic            add_ovf_w, sub_ovf_w, slt_w;
  logic            op_signed_w;
  logic [SIZE-1:0] a_mag_w, b_mag_w;

  assign sum_w       = bus.a + bus.b;
  assign diff_w      = bus.a - bus.b;
  assign add_ovf_w   = (bus.a[SIZE-1] == bus.b[SIZE-1]) && (sum_w[SIZE-1] != bus.a[SIZE-1]);
  assign sub_ovf_w   = (bus.a[SIZE-1] != bus.b[SIZE-1]) && (diff_w[SIZE-1] != bus.a[SIZE-1]);
  assign slt_w       = $signed(bus.a) < $signed(bus.b);
  // MULT and DIV have opcode bit 0 clear; the unsigned variants have it set.
  assign op_signed_w = ~bus.ALUOp[0];
  // Magnitude of the most negative value is 2**(SIZE-1), which still fits unsigned.
  assign a_mag_w     = (op_signed_w && bus.a[SIZE-1]) ? -bus.a : bus.a;
  assign b_mag_w     = (op_signed_w && bus.b[SIZE-1]) ? -bus.b : bus.b;

  // ---------------- shift-add multiplier step ----------------
  logic [SIZE:0]     mul_sum_w;
  logic [2*SIZE-1:0] mul_next_w, prod_fix_w;

  assign mul_sum_w  = {1'b0, work_q[2*SIZE-1:SIZE]} + {1'b0, mcand_q};
  assign mul_next_w = work_q[0] ? {mul_sum_w, work_q[SIZE-1:1]}
                                : {1'b0, work_q[2*SIZE-1:1]};
  assign prod_fix_w = neg_lo_q ? -mul_next_w : mul_next_w;

`ifdef MIPS_ALU_DIV_EN
  // ---------------- restoring divider step ----------------
  logic [SIZE:0]     rem_sh_w;
  logic [SIZE-1:0]   trial_w;
  logic              q_bit_w;
  logic [2*SIZE-1:0] div_next_w;
  logic [SIZE-1:0]   quo_fix_w, rem_fix_w;

  assign rem_sh_w   = {work_q[2*SIZE-1:SIZE], work_q[SIZE-1]};
  assign q_bit_w    = (rem_sh_w >= {1'b0, mcand_q});
  // Only used when the subtraction fits, so the top bit is known to be zero.
  assign trial_w    = rem_sh_w[SIZE-1:0] - mcand_q;
  assign div_next_w = {(q_bit_w ? trial_w : rem_sh_w[SIZE-1:0]),
                       work_q[SIZE-2:0], q_bit_w};
  assign quo_fix_w  = neg_lo_q ? -div_next_w[SIZE-1:0] : div_next_w[SIZE-1:0];
  assign rem_fix_w  = neg_hi_q ? -div_next_w[2*SIZE-1:SIZE] : div_next_w[2*SIZE-1:SIZE];
`endif

  // Next-state and datapath update; every register holds unless touched below.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    work_d   = work_q;
    mcand_d  = mcand_q;
    neg_lo_d = neg_lo_q;
`ifdef MIPS_ALU_DIV_EN
    neg_hi_d = neg_hi_q;
    is_div_d = is_div_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          cnt_d   = '0;
          ovf_d   = 1'b0;
          dz_d    = 1'b0;
          state_d = S_DONE;
          case (bus.ALUOp)
            OP_AND: lo_d = bus.a & bus.b;
            OP_OR:  lo_d = bus.a | bus.b;
            OP_NOR: lo_d = ~(bus.a | bus.b);
            OP_ADD: begin
              lo_d  = sum_w;
              ovf_d = add_ovf_w;
            end
            OP_SUB: begin
              lo_d  = diff_w;
              ovf_d = sub_ovf_w;
            end
            OP_SLT: lo_d = {{(SIZE-1){1'b0}}, slt_w};
            OP_MULT, OP_MULTU: begin
              mcand_d  = a_mag_w;
              work_d   = {{SIZE{1'b0}}, b_mag_w};
              neg_lo_d = op_signed_w && (bus.a[SIZE-1] ^ bus.b[SIZE-1]);
`ifdef MIPS_ALU_DIV_EN
              is_div_d = 1'b0;
`endif
              state_d  = S_BUSY;
            end
`ifdef MIPS_ALU_DIV_EN
            OP_DIV, OP_DIVU: begin
              if (bus.b == '0) begin
                // Division by zero skips the loop entirely.
                lo_d = '0;
                hi_d = bus.a;
                dz_d = 1'b1;
              end else begin
                mcand_d  = b_mag_w;
                work_d   = {{SIZE{1'b0}}, a_mag_w};
                neg_lo_d = op_signed_w && (bus.a[SIZE-1] ^ bus.b[SIZE-1]);
                neg_hi_d = op_signed_w && bus.a[SIZE-1];
                is_div_d = 1'b1;
                state_d  = S_BUSY;
              end
            end
`endif
            default: lo_d = '0;
          endcase
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
`ifdef MIPS_ALU_DIV_EN
        work_d = is_div_q ? div_next_w : mul_next_w;
`else
        work_d = mul_next_w;
`endif
        if (cnt_q == CNT_LAST) begin
          // Last iteration: apply the result sign and publish HI/LO.
          cnt_d   = '0;
          state_d = S_DONE;
`ifdef MIPS_ALU_DIV_EN
          if (is_div_q) begin
            lo_d = quo_fix_w;
            hi_d = rem_fix_w;
          end else begin
            lo_d = prod_fix_w[SIZE-1:0];
            hi_d = prod_fix_w[2*SIZE-1:SIZE];
          end
`else
          lo_d = prod_fix_w[SIZE-1:0];
          hi_d = prod_fix_w[2*SIZE-1:SIZE];
`endif
        end
      end

      S_DONE: begin
        // No same-cycle re-accept: in_ready is low here, so one bubble per op.
        if (bus.out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      work_q   <= '0;
      mcand_q  <= '0;
      neg_lo_q <= 1'b0;
`ifdef MIPS_ALU_DIV_EN
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      work_q   <= work_d;
      mcand_q  <= mcand_d;
      neg_lo_q <= neg_lo_d;
`ifdef MIPS_ALU_DIV_EN
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.outCalc   = lo_q;
  assign bus.hi        = hi_q;
  assign bus.zero      = (lo_q == '0);
  assign bus.overflow  = ovf_q;
  assign bus.div_zero  = dz_q;

endmodule
